// File: rtl/wb_stage_multi.sv
// wb_stage_multi
// Multi-lane write-back stage. It retires up to LANES results per cycle to the
// register file and the ID forwarding path. When two lanes of a group write the
// same register, only the youngest one writes. Every retired lane is also queued
// in a trace FIFO and drained one entry per cycle onto the single debug port.

module wb_stage_multi #(
  parameter int LANES       = 2,
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int PCW         = 32,
  parameter int STALL_W     = 6,
  parameter int STALL_IDX   = 4,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [STALL_W-1:0]              stall,
  input  logic                            flush,
  input  logic [LANES*(1+PCW+1+AW+DW)-1:0] mem_to_wb_bus,
  output logic [LANES*(1+AW+DW)-1:0]      wb_to_rf_bus,
  output logic [LANES*(1+AW+DW)-1:0]      wb_to_id_bus,
  output logic                            stallreq_wb,
  output logic                            debug_wb_valid,
  output logic [PCW-1:0]                  debug_wb_pc,
  output logic [3:0]                      debug_wb_rf_wen,
  output logic [AW-1:0]                   debug_wb_rf_wnum,
  output logic [DW-1:0]                   debug_wb_rf_wdata,
  output logic                            trace_overflow
);

  // Width of one lane on the incoming bus, on the RF bus, and in the trace FIFO.
  localparam int LW   = 1 + PCW + 1 + AW + DW;
  localparam int OW   = 1 + AW + DW;
  localparam int EW   = PCW + 1 + AW + DW;
  localparam int PTRW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int CW   = $clog2(TRACE_DEPTH + 1);

  // Stage register. The PC is only needed by the trace path, and that path
  // reads the incoming group, so the PC is not stored here.
  logic [LANES-1:0]    stg_valid_q;
  logic [LANES-1:0]    stg_we_q;
  logic [LANES*AW-1:0] stg_addr_q;
  logic [LANES*DW-1:0] stg_data_q;
  logic [LANES-1:0]    stg_we_eff;

  // Incoming group, split into separate fields.
  logic [LANES-1:0]     in_valid;
  logic [LANES-1:0]     in_we;
  logic [LANES-1:0]     in_we_eff;
  logic [LANES*AW-1:0]  in_addr;
  logic [LANES*DW-1:0]  in_data;
  logic [LANES*PCW-1:0] in_pc;

  // Stage control derived from this stage's stall bit and the next stage's stall bit.
  logic load_en;
  logic bubble_en;
  logic push_go;

  // Trace FIFO state and the per-cycle push/pop decisions.
  logic [EW-1:0]   trace_mem [TRACE_DEPTH];
  logic [PTRW-1:0] wr_ptr_q;
  logic [PTRW-1:0] rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            pop;
  logic [CW:0]     free_slots;
  logic [CW:0]     push_cnt;
  logic [LANES-1:0] push_lane;
  logic [PTRW-1:0] lane_slot [LANES];
  logic            drop;
  logic [EW-1:0]   head_entry;

  // Only two stall bits matter to this stage. The rest are folded into a
  // deliberately unused net.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  assign load_en   = ~stall[STALL_IDX];
  assign bubble_en = stall[STALL_IDX] & ~stall[STALL_IDX+1];
  assign push_go   = load_en & ~flush;

  // A lane writes if it is valid, has we set and targets a register other than
  // r0. A younger lane to the same register cancels an older lane's write.
  function automatic logic [LANES-1:0] resolve_we(input logic [LANES-1:0]    valid,
                                                  input logic [LANES-1:0]    we,
                                                  input logic [LANES*AW-1:0] addr);
    logic [LANES-1:0] raw;
    logic [LANES-1:0] res;
    for (int i = 0; i < LANES; i++) begin
      raw[i] = valid[i] & we[i] & (addr[i*AW +: AW] != '0);
    end
    res = raw;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (raw[j] && (addr[j*AW +: AW] == addr[i*AW +: AW])) begin
          res[i] = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Split the incoming bus into fields. Each lane is {valid, pc, we, waddr, wdata}.
  always_comb begin
    in_valid = '0;
    in_we    = '0;
    in_addr  = '0;
    in_data  = '0;
    in_pc    = '0;
    for (int i = 0; i < LANES; i++) begin
      in_data[i*DW +: DW]   = mem_to_wb_bus[i*LW +: DW];
      in_addr[i*AW +: AW]   = mem_to_wb_bus[i*LW + DW +: AW];
      in_we[i]              = mem_to_wb_bus[i*LW + DW + AW];
      in_pc[i*PCW +: PCW]   = mem_to_wb_bus[i*LW + DW + AW + 1 +: PCW];
      in_valid[i]           = mem_to_wb_bus[i*LW + LW - 1];
    end
  end

  assign in_we_eff  = resolve_we(in_valid, in_we, in_addr);
  assign stg_we_eff = resolve_we(stg_valid_q, stg_we_q, stg_addr_q);

  // Update the stage register. Priority is flush, then bubble, then load; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid_q <= '0;
      stg_we_q    <= '0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else if (flush || bubble_en) begin
      stg_valid_q <= '0;
      stg_we_q    <= '0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else if (load_en) begin
      stg_valid_q <= in_valid;
      stg_we_q    <= in_we;
      stg_addr_q  <= in_addr;
      stg_data_q  <= in_data;
    end
  end

  // Drive the RF and ID buses from the stage register, using the resolved write enables.
  always_comb begin
    wb_to_rf_bus = '0;
    for (int i = 0; i < LANES; i++) begin
      wb_to_rf_bus[i*OW +: OW] = {stg_we_eff[i], stg_addr_q[i*AW +: AW], stg_data_q[i*DW +: DW]};
    end
  end

  assign wb_to_id_bus = wb_to_rf_bus;

  // The consumer drains one entry per cycle. Free space includes the slot that
  // this cycle's pop releases.
  assign pop        = (count_q != '0);
  assign free_slots = (CW+1)'(TRACE_DEPTH) - (CW+1)'(count_q) + (CW+1)'(pop);

  // Place valid incoming lanes into consecutive slots, oldest lane first. Lanes
  // that do not fit are dropped, so the youngest lanes are lost first.
  always_comb begin
    push_cnt  = '0;
    push_lane = '0;
    drop      = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_slot[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (push_go && in_valid[i]) begin
        if (push_cnt < free_slots) begin
          push_lane[i] = 1'b1;
          lane_slot[i] = wr_ptr_q + PTRW'(push_cnt);
          push_cnt     = push_cnt + (CW+1)'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Update the FIFO pointers, the occupancy count and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_q + PTRW'(push_cnt);
      rd_ptr_q   <= rd_ptr_q + PTRW'(pop);
      count_q    <= count_q + CW'(push_cnt) - CW'(pop);
      overflow_q <= overflow_q | drop;
    end
  end

  // Write accepted lanes into trace storage. Storage is not reset because it is
  // only read while count is non-zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_lane[i]) begin
        trace_mem[lane_slot[i]] <= {in_pc[i*PCW +: PCW], in_we_eff[i],
                                    in_addr[i*AW +: AW], in_data[i*DW +: DW]};
      end
    end
  end

  assign head_entry = trace_mem[rd_ptr_q];

  // Present the FIFO head on the debug port. All debug outputs are zero while the FIFO is empty.
  always_comb begin
    debug_wb_valid    = 1'b0;
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (count_q != '0) begin
      debug_wb_valid    = 1'b1;
      debug_wb_pc       = head_entry[EW-1 -: PCW];
      debug_wb_rf_wen   = {4{head_entry[DW+AW]}};
      debug_wb_rf_wnum  = head_entry[DW +: AW];
      debug_wb_rf_wdata = head_entry[DW-1:0];
    end
  end

  assign stallreq_wb    = (CW+1)'(count_q) > (CW+1)'(TRACE_DEPTH - LANES);
  assign trace_overflow = overflow_q;

endmodule
